// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Contents : Shared definitions for the Coprocessor-0 block. These are the
//            register numbers, exception codes, the handler vector, the field
//            positions of SR and Cause, and the helpers that pack them into
//            32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  // CP0 register numbers seen by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes carried down the pipe (0 doubles as "no exception")
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // Exception vector; the next-PC logic uses the same constant
  localparam logic [31:0] EXC_HANDLER_ADDR = 32'h0000_4180;

  // SR bit positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;
  localparam int SR_IM_MSB  = 15;

  // Cause bit positions
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  // Only the implemented fields are stored; every other bit reads as zero
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_MSB:SR_IM_LSB] = s.im;
    w[SR_EXL_BIT]          = s.exl;
    w[SR_IE_BIT]           = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD_BIT]                = c.bd;
    w[CAUSE_IP_MSB:CAUSE_IP_LSB]   = c.ip;
    w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = c.exc_code;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : cp0_req_gen
// Contents : Combinational exception/interrupt request logic. It decides
//            whether the M-stage instruction is diverted to the handler and
//            which ExcCode gets recorded.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_req_gen
  import cp0_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] sr_im,
  input  logic       sr_ie,
  input  logic       sr_exl,
  input  logic [4:0] exc_in,
  output logic       req,
  output logic [4:0] next_exc_code
);

  logic w_int_req;
  logic w_exc_req;

  // EXL masks both sources; an interrupt wins over a synchronous exception
  always_comb begin
    w_int_req     = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    w_exc_req     = (exc_in != 5'd0) & ~sr_exl;
    req           = w_int_req | w_exc_req;
    next_exc_code = w_int_req ? EXC_INT : exc_in;
  end

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Contents : Coprocessor-0 for the P7 pipeline, located at the M stage.
//            It holds SR, Cause, EPC and PRId. It raises req to divert fetch
//            to the handler and exports EPC for eret.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h4255_4141,
  parameter logic [31:0] HANDLER_ADDR = EXC_HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  a_wr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req
);

  sr_t         r_sr;
  cause_t      r_cause;
  logic [31:0] r_epc;

  logic        w_req;
  logic [4:0]  w_next_exc_code;
  logic [31:0] w_vpc_aligned;
  logic [31:0] w_epc_exc;

  cp0_req_gen u_req_gen (
    .hw_int        (hw_int),
    .sr_im         (r_sr.im),
    .sr_ie         (r_sr.ie),
    .sr_exl        (r_sr.exl),
    .exc_in        (exc_in),
    .req           (w_req),
    .next_exc_code (w_next_exc_code)
  );

  assign req     = w_req;
  assign epc_out = r_epc;

  // A delay-slot fault restarts at the branch, one word before the slot
  always_comb begin
    w_vpc_aligned = vpc & 32'hFFFF_FFFC;
    w_epc_exc     = bd_in ? (w_vpc_aligned - 32'd4) : w_vpc_aligned;
  end

  // CP0 state update. IP samples the lines every cycle. A request masks the
  // faulting instruction's mtc0/eret. eret clears EXL after any SR write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sr    <= '0;
      r_cause <= '0;
      r_epc   <= '0;
    end else begin
      r_cause.ip <= hw_int;
      if (w_req) begin
        r_sr.exl         <= 1'b1;
        r_cause.exc_code <= w_next_exc_code;
        r_cause.bd       <= bd_in;
        r_epc            <= w_epc_exc;
      end else begin
        if (we && (a_wr == CP0_SR)) begin
          r_sr.im  <= din[SR_IM_MSB:SR_IM_LSB];
          r_sr.exl <= din[SR_EXL_BIT];
          r_sr.ie  <= din[SR_IE_BIT];
        end
        if (we && (a_wr == CP0_EPC)) begin
          r_epc <= {din[31:2], 2'b00};
        end
        if (exl_clr) begin
          r_sr.exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read port. It returns the pre-edge register contents.
  always_comb begin
    dout = '0;
    case (a_rd)
      CP0_SR:    dout = pack_sr(r_sr);
      CP0_CAUSE: dout = pack_cause(r_cause);
      CP0_EPC:   dout = r_epc;
      CP0_PRID:  dout = PRID_VALUE;
      default:   dout = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_unit
// Contents : Self-checking bench for cp0_unit. It runs directed scenarios and
//            then randomized traffic against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h4255_4141;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  a_rd;
  logic [4:0]  a_wr;
  logic [31:0] din;
  logic        we;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        req;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference state kept as architectural 32-bit words
  logic [31:0] m_sr    = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc   = '0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a_rd    (a_rd),
    .a_wr    (a_wr),
    .din     (din),
    .we      (we),
    .vpc     (vpc),
    .bd_in   (bd_in),
    .exc_in  (exc_in),
    .hw_int  (hw_int),
    .exl_clr (exl_clr),
    .dout    (dout),
    .epc_out (epc_out),
    .req     (req)
  );

  function automatic logic model_int();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    return model_int() || ((exc_in != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] r);
    case (r)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: compute the architectural next state from the current inputs
  task automatic tick();
    logic [31:0] n_sr, n_cause, n_epc;
    n_sr    = m_sr;
    n_cause = (m_cause & ~32'h0000_FC00) | {16'd0, hw_int, 10'd0};
    n_epc   = m_epc;
    if (!reset_n) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else if (model_req()) begin
      n_sr        = m_sr | 32'h2;
      n_cause[31] = bd_in;
      n_cause[6:2] = model_int() ? 5'd0 : exc_in;
      n_epc       = (vpc & 32'hFFFF_FFFC) - (bd_in ? 32'd4 : 32'd0);
    end else begin
      if (we && a_wr == 5'd12) n_sr = din & 32'h0000_FC03;
      if (we && a_wr == 5'd14) n_epc = din & 32'hFFFF_FFFC;
      if (exl_clr) n_sr = n_sr & ~32'h2;
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    #2;
  endtask

  task automatic idle();
    we = 0; a_wr = 0; din = 0; exl_clr = 0; exc_in = 0; bd_in = 0; vpc = 32'h0000_1000;
  endtask

  task automatic write_cp0(input logic [4:0] r, input logic [31:0] d);
    we = 1; a_wr = r; din = d;
    tick();
    we = 0; a_wr = 0; din = 0;
  endtask

  task automatic test_reset();
    idle(); hw_int = 0; a_rd = 0;
    reset_n = 0; tick(); tick(); reset_n = 1;
    a_rd = 12; #1; total_cnt++;
    if (dout !== 32'd0) $display("FAIL reset_sr: got %h expected %h", dout, 32'd0); else pass_cnt++;
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'd0) $display("FAIL reset_cause: got %h expected %h", dout, 32'd0); else pass_cnt++;
    a_rd = 14; #1; total_cnt++;
    if (dout !== 32'd0) $display("FAIL reset_epc: got %h expected %h", dout, 32'd0); else pass_cnt++;
    a_rd = 15; #1; total_cnt++;
    if (dout !== PRID) $display("FAIL reset_prid: got %h expected %h", dout, PRID); else pass_cnt++;
    total_cnt++;
    if (req !== 1'b0 || epc_out !== 32'd0)
      $display("FAIL reset_req_epc: got req=%b epc=%h expected req=0 epc=0", req, epc_out);
    else pass_cnt++;
  endtask

  task automatic test_interrupt();
    idle(); hw_int = 0;
    write_cp0(12, 32'h0000_FC01);
    hw_int = 6'b000100; #1; total_cnt++;
    if (req !== 1'b1) $display("FAIL int_req: got %b expected 1", req); else pass_cnt++;
    tick();
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'h0000_1000) $display("FAIL int_cause: got %h expected %h", dout, 32'h0000_1000); else pass_cnt++;
    a_rd = 12; #1; total_cnt++;
    if (dout !== 32'h0000_FC03 || req !== 1'b0)
      $display("FAIL int_exl: got sr=%h req=%b expected sr=0000fc03 req=0", dout, req);
    else pass_cnt++;
    hw_int = 0;
    write_cp0(12, 32'h0);
  endtask

  task automatic test_exc_delay_slot();
    idle();
    exc_in = 5'd12; bd_in = 1; vpc = 32'h0000_3008; #1; total_cnt++;
    if (req !== 1'b1) $display("FAIL ov_req: got %b expected 1", req); else pass_cnt++;
    tick(); idle();
    a_rd = 14; #1; total_cnt++;
    if (dout !== 32'h0000_3004 || epc_out !== 32'h0000_3004)
      $display("FAIL ov_epc: got dout=%h epc_out=%h expected 00003004", dout, epc_out);
    else pass_cnt++;
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'h8000_0030) $display("FAIL ov_cause: got %h expected %h", dout, 32'h8000_0030); else pass_cnt++;
  endtask

  // Entered with EXL=1 and EPC=0x3004 from the previous scenario
  task automatic test_exl_mask();
    idle();
    exc_in = 5'd10; vpc = 32'h0000_0100; #1; total_cnt++;
    if (req !== 1'b0) $display("FAIL ri_masked_req: got %b expected 0", req); else pass_cnt++;
    tick(); idle();
    a_rd = 14; #1; total_cnt++;
    if (dout !== 32'h0000_3004) $display("FAIL ri_masked_epc: got %h expected %h", dout, 32'h0000_3004); else pass_cnt++;
    exl_clr = 1; tick(); exl_clr = 0;
    a_rd = 12; #1; total_cnt++;
    if (dout !== 32'd0) $display("FAIL eret_sr: got %h expected %h", dout, 32'd0); else pass_cnt++;
    exc_in = 5'd10; vpc = 32'h0000_2000; #1; total_cnt++;
    if (req !== 1'b1) $display("FAIL ri_req: got %b expected 1", req); else pass_cnt++;
    tick(); idle();
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'h0000_0028) $display("FAIL ri_cause: got %h expected %h", dout, 32'h0000_0028); else pass_cnt++;
    exl_clr = 1; tick(); exl_clr = 0;
  endtask

  task automatic test_mtc0_vs_req();
    idle();
    we = 1; a_wr = 14; din = 32'h0000_5000; exc_in = 5'd4; vpc = 32'h0000_1234; #1; total_cnt++;
    if (req !== 1'b1) $display("FAIL adel_req: got %b expected 1", req); else pass_cnt++;
    tick(); idle();
    total_cnt++;
    if (epc_out !== 32'h0000_1234) $display("FAIL adel_epc: got %h expected %h", epc_out, 32'h0000_1234); else pass_cnt++;
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'h0000_0010) $display("FAIL adel_cause: got %h expected %h", dout, 32'h0000_0010); else pass_cnt++;
    exl_clr = 1; tick(); exl_clr = 0;
  endtask

  task automatic test_pending_int_after_eret();
    idle(); hw_int = 0;
    write_cp0(12, 32'h0000_0403);
    hw_int = 6'b000001; #1; total_cnt++;
    if (req !== 1'b0) $display("FAIL pend_masked: got %b expected 0", req); else pass_cnt++;
    exl_clr = 1; #1; total_cnt++;
    if (req !== 1'b0) $display("FAIL pend_eret_cycle: got %b expected 0", req); else pass_cnt++;
    tick(); exl_clr = 0; #1; total_cnt++;
    if (req !== 1'b1) $display("FAIL pend_fire: got %b expected 1", req); else pass_cnt++;
    tick();
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'h0000_0400) $display("FAIL pend_cause: got %h expected %h", dout, 32'h0000_0400); else pass_cnt++;
    hw_int = 0;
    // Same-cycle mtc0 SR and eret: EXL ends up clear
    we = 1; a_wr = 12; din = 32'h0000_0403; exl_clr = 1;
    tick(); idle();
    a_rd = 12; #1; total_cnt++;
    if (dout !== 32'h0000_0401) $display("FAIL eret_mtc0_sr: got %h expected %h", dout, 32'h0000_0401); else pass_cnt++;
    write_cp0(12, 32'h0);
  endtask

  task automatic test_boundaries();
    idle(); hw_int = 0;
    exc_in = 5'd5; bd_in = 1; vpc = 32'h0000_0002;
    tick(); idle();
    total_cnt++;
    if (epc_out !== 32'hFFFF_FFFC) $display("FAIL epc_wrap: got %h expected %h", epc_out, 32'hFFFF_FFFC); else pass_cnt++;
    exl_clr = 1; tick(); exl_clr = 0;
    write_cp0(13, 32'hFFFF_FFFF);
    write_cp0(15, 32'h0);
    a_rd = 13; #1; total_cnt++;
    if (dout !== 32'h8000_0014) $display("FAIL cause_readonly: got %h expected %h", dout, 32'h8000_0014); else pass_cnt++;
    a_rd = 15; #1; total_cnt++;
    if (dout !== PRID) $display("FAIL prid_readonly: got %h expected %h", dout, PRID); else pass_cnt++;
    write_cp0(14, 32'h1234_567B);
    total_cnt++;
    if (epc_out !== 32'h1234_5678) $display("FAIL epc_align: got %h expected %h", epc_out, 32'h1234_5678); else pass_cnt++;
    a_rd = 5'd20; #1; total_cnt++;
    if (dout !== 32'd0) $display("FAIL rd_other: got %h expected %h", dout, 32'd0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_handler();
    idle(); hw_int = 0;
    write_cp0(12, 32'h0000_0401);
    exc_in = 5'd8; tick(); idle();
    hw_int = 6'b000001;
    reset_n = 0; tick(); reset_n = 1;
    a_rd = 12; #1; total_cnt++;
    if (dout !== 32'd0 || req !== 1'b0)
      $display("FAIL reset_mid_handler: got sr=%h req=%b expected sr=0 req=0", dout, req);
    else pass_cnt++;
    tick(); total_cnt++;
    if (req !== 1'b0) $display("FAIL reset_int_disabled: got %b expected 0", req); else pass_cnt++;
    hw_int = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      exc_in  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      hw_int  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      we      = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: a_wr = 5'd12;
        1: a_wr = 5'd13;
        2: a_wr = 5'd14;
        3: a_wr = 5'd15;
        default: a_wr = 5'($urandom);
      endcase
      din     = $urandom;
      exl_clr = ($urandom_range(0, 4) == 0);
      vpc     = $urandom;
      bd_in   = 1'($urandom);
      a_rd    = 5'($urandom_range(10, 17));
      #1;
      total_cnt++;
      if (req !== model_req()) $display("FAIL rnd_req[%0d]: got %b expected %b", i, req, model_req()); else pass_cnt++;
      total_cnt++;
      if (dout !== model_rd(a_rd))
        $display("FAIL rnd_dout[%0d] reg %0d: got %h expected %h", i, a_rd, dout, model_rd(a_rd));
      else pass_cnt++;
      total_cnt++;
      if (epc_out !== m_epc) $display("FAIL rnd_epc[%0d]: got %h expected %h", i, epc_out, m_epc); else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 0; a_rd = 0; hw_int = 0;
    idle();
    test_reset();
    test_interrupt();
    test_exc_delay_slot();
    test_exl_mask();
    test_mtc0_vs_req();
    test_pending_int_after_eret();
    test_boundaries();
    test_reset_mid_handler();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
